// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester main-memory arbiter.
package mem_arbiter_pkg;

    // Arbiter FSM encodings; gnt0/gnt1 map straight onto the OWN bits
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    // Requester identifiers carried in the read-return tag
    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    // Bank select field within a word address
    localparam int unsigned BANK_LSB  = 1;
    localparam int unsigned BANK_MSB  = 2;
    localparam int unsigned BANK_W    = BANK_MSB - BANK_LSB + 1;
    localparam int unsigned NUM_BANKS = 1 << BANK_W;

    // Read-return tag: which requester an in-flight read belongs to
    typedef struct packed {
        logic valid;
        logic owner;
    } rd_tag_t;

endpackage

// File: rtl/mem_arbiter_rd_tag_pipe.sv
// Delay line carrying {valid, owner} for each accepted read so the
// returning data can be steered to the requester that issued it.
module mem_arbiter_rd_tag_pipe
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned RD_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  logic i_owner,
    output logic o_valid,
    output logic o_owner
);

    rd_tag_t r_pipe [RD_LAT];

    // Shift tags one stage per cycle; reset drops anything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(RD_LAT); i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= '{valid: i_push, owner: i_owner};
            for (int i = 1; i < int'(RD_LAT); i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_valid = r_pipe[RD_LAT-1].valid;
    assign o_owner = r_pipe[RD_LAT-1].owner;

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the four-bank main memory between the I-cache (0)
// and D-cache (1) controllers: round-robin grant with burst lock,
// per-bank busy gating and tagged read-data return.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned AW     = 16,
    parameter int unsigned DW     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 rd0,
    input  logic                 rd1,
    input  logic                 wr0,
    input  logic                 wr1,
    input  logic                 lock0,
    input  logic                 lock1,
    input  logic [AW-1:0]        addr0,
    input  logic [AW-1:0]        addr1,
    input  logic [DW-1:0]        wdata0,
    input  logic [DW-1:0]        wdata1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 ack0,
    output logic                 ack1,
    output logic                 rvalid0,
    output logic                 rvalid1,
    output logic [DW-1:0]        rdata,
    output logic                 err,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata,
    input  logic                 mem_stall,
    input  logic [NUM_BANKS-1:0] mem_busy
);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       r_ptr;
    logic       w_ptr_nxt;

    logic       w_own0;
    logic       w_own1;
    logic       w_bank_free0;
    logic       w_bank_free1;
    logic       w_issue0;
    logic       w_issue1;
    logic       w_push;
    logic       w_push_owner;
    logic       w_tag_valid;
    logic       w_tag_owner;

    assign w_own0 = (r_state == ST_OWN0);
    assign w_own1 = (r_state == ST_OWN1);

    assign w_bank_free0 = ~mem_busy[addr0[BANK_MSB:BANK_LSB]];
    assign w_bank_free1 = ~mem_busy[addr1[BANK_MSB:BANK_LSB]];

    // A word access goes out only from the owner, one direction at a time
    assign w_issue0 = w_own0 & req0 & (rd0 ^ wr0) & ~mem_stall & w_bank_free0;
    assign w_issue1 = w_own1 & req1 & (rd1 ^ wr1) & ~mem_stall & w_bank_free1;

    // State and round-robin pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= REQ_I;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Grant selection: tie goes to the side not last served; owner keeps
    // the grant while requesting or locked, and hands off without a bubble
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (req0 && req1) begin
                    w_state_nxt = (r_ptr == REQ_I) ? ST_OWN1 : ST_OWN0;
                end else if (req1) begin
                    w_state_nxt = ST_OWN1;
                end else if (req0) begin
                    w_state_nxt = ST_OWN0;
                end
            end
            ST_OWN0: begin
                if (!req0 && !lock0) begin
                    w_ptr_nxt   = REQ_I;
                    w_state_nxt = req1 ? ST_OWN1 : ST_IDLE;
                end
            end
            ST_OWN1: begin
                if (!req1 && !lock1) begin
                    w_ptr_nxt   = REQ_D;
                    w_state_nxt = req0 ? ST_OWN0 : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Memory strobes and acks; address and data are held at zero when idle
    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        if (w_issue0) begin
            mem_rd    = rd0;
            mem_wr    = wr0;
            mem_addr  = addr0;
            mem_wdata = wdata0;
            ack0      = 1'b1;
        end else if (w_issue1) begin
            mem_rd    = rd1;
            mem_wr    = wr1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
            ack1      = 1'b1;
        end
    end

    assign gnt0 = w_own0;
    assign gnt1 = w_own1;

    // Simultaneous read and write from the owner is rejected and flagged
    assign err = (w_own0 & rd0 & wr0) | (w_own1 & rd1 & wr1);

    assign w_push       = (w_issue0 & rd0) | (w_issue1 & rd1);
    assign w_push_owner = w_issue1 ? REQ_D : REQ_I;

    mem_arbiter_rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_owner (w_push_owner),
        .o_valid (w_tag_valid),
        .o_owner (w_tag_owner)
    );

    // The exiting tag, not the current grant, decides who gets the data
    assign rvalid0 = w_tag_valid & (w_tag_owner == REQ_I);
    assign rvalid1 = w_tag_valid & (w_tag_owner == REQ_D);
    assign rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a read-return scoreboard.
module tb_mem_arbiter;

    localparam int unsigned RD_LAT = 2;
    localparam int unsigned AW     = 16;
    localparam int unsigned DW     = 16;

    logic          clk;
    logic          rst;
    logic          req0, req1, rd0, rd1, wr0, wr1, lock0, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, ack0, ack1, rvalid0, rvalid1, err;
    logic [DW-1:0] rdata;
    logic          mem_rd, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_stall;
    logic [3:0]    mem_busy;

    mem_arbiter #(
        .RD_LAT (RD_LAT),
        .AW     (AW),
        .DW     (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .rd0       (rd0),
        .rd1       (rd1),
        .wr0       (wr0),
        .wr1       (wr1),
        .lock0     (lock0),
        .lock1     (lock1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .ack0      (ack0),
        .ack1      (ack1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata     (rdata),
        .err       (err),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_stall (mem_stall),
        .mem_busy  (mem_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Memory model: data for a read at address a is a ^ 16'h5A5A, RD_LAT cycles later
    logic [DW-1:0] r_mp1;
    always @(posedge clk) begin
        r_mp1     <= mem_rd ? (mem_addr ^ 16'h5A5A) : 16'hDEAD;
        mem_rdata <= r_mp1;
    end

    typedef struct {
        int            due;
        logic          owner;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];

    task automatic push_rd(input logic owner, input logic [AW-1:0] a);
        sb.push_back('{due: cyc + int'(RD_LAT), owner: owner, data: a ^ 16'h5A5A});
    endtask

    // Scoreboard consumer: compares every cycle where a return is due or seen
    exp_t          m_e;
    logic          m_v0, m_v1;
    logic [DW-1:0] m_d;
    always @(negedge clk) begin
        m_v0 = 1'b0;
        m_v1 = 1'b0;
        m_d  = '0;
        if (sb.size() > 0 && sb[0].due < cyc) begin
            check("sb_late", 32'(cyc), 32'(sb[0].due));
            m_e = sb.pop_front();
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            m_e  = sb.pop_front();
            m_v0 = ~m_e.owner;
            m_v1 = m_e.owner;
            m_d  = m_e.data;
        end
        if (m_v0 || m_v1 || rvalid0 || rvalid1) begin
            check("rvalid0", 32'(rvalid0), 32'(m_v0));
            check("rvalid1", 32'(rvalid1), 32'(m_v1));
            if (m_v0 || m_v1) check("rdata", 32'(rdata), 32'(m_d));
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        req0 = 0; req1 = 0; rd0 = 0; rd1 = 0; wr0 = 0; wr1 = 0;
        lock0 = 0; lock1 = 0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        mem_stall = 0; mem_busy = '0;
    endtask

    function automatic logic [8:0] all_outs();
        return {gnt0, gnt1, ack0, ack1, mem_rd, mem_wr, err, rvalid0, rvalid1};
    endfunction

    task automatic do_reset();
        next();
        rst = 1;
        clear_inputs();
        sb.delete();
        smp();
        check("reset_outs", 32'(all_outs()), 0);
        check("reset_addr", 32'(mem_addr), 0);
        next();
        next();
        rst = 0;
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        repeat (2) next();
        smp();
        check("por_outs", 32'(all_outs()), 0);
        next();
        rst = 0;

        // Single read from requester 1
        next(); req1 = 1; rd1 = 1; addr1 = 16'h0010;
        smp(); check("t1_wait", 32'({gnt1, ack1, mem_rd}), 0);
        next(); push_rd(1'b1, 16'h0010);
        smp(); check("t1_issue", 32'({gnt1, ack1, mem_rd}), 3'b111);
        check("t1_addr", 32'(mem_addr), 16'h0010);
        next(); rd1 = 0; req1 = 0;
        smp(); check("t1_noack", 32'({gnt1, ack1}), 2'b10);
        next();
        smp(); check("t1_release", 32'({gnt0, gnt1}), 0);
        repeat (2) next();

        // Round-robin from a fresh reset
        do_reset();
        next(); req0 = 1; req1 = 1;
        smp();
        next();
        smp(); check("rr_first", 32'({gnt0, gnt1}), 2'b01);
        next(); req1 = 0;
        smp();
        next();
        smp(); check("rr_handoff", 32'({gnt0, gnt1}), 2'b10);
        next(); req1 = 1;
        smp(); check("rr_hold0", 32'({gnt0, gnt1}), 2'b10);
        next(); req0 = 0;
        smp();
        next();
        smp(); check("rr_back1", 32'({gnt0, gnt1}), 2'b01);
        next(); req1 = 0;
        smp();
        next();
        smp(); check("rr_idle", 32'({gnt0, gnt1}), 0);
        next(); req0 = 1; req1 = 1;
        smp();
        next();
        smp(); check("rr_idle_tie", 32'({gnt0, gnt1}), 2'b10);

        // Lock holds grant with req low
        next(); req0 = 0;
        smp();
        next();
        smp(); check("lk_own1", 32'({gnt0, gnt1}), 2'b01);
        next(); req0 = 1; req1 = 0; lock1 = 1;
        for (int i = 0; i < 3; i++) begin
            smp(); check("lk_hold", 32'({gnt0, gnt1}), 2'b01);
            next();
        end
        lock1 = 0;
        smp(); check("lk_last", 32'({gnt0, gnt1}), 2'b01);
        next();
        smp(); check("lk_release", 32'({gnt0, gnt1}), 2'b10);

        // Bank busy gating, other bank proceeds, stall, non-owner ignored
        next(); rd0 = 1; addr0 = 16'h0002; mem_busy = 4'b0010;
        for (int i = 0; i < 2; i++) begin
            smp(); check("bsy_wait", 32'({ack0, mem_rd}), 0);
            next();
        end
        mem_busy = 4'b0000; push_rd(1'b0, 16'h0002);
        smp(); check("bsy_ack", 32'({ack0, mem_rd}), 2'b11);
        check("bsy_addr", 32'(mem_addr), 16'h0002);
        next(); rd0 = 0; wr0 = 1; addr0 = 16'h0004; wdata0 = 16'hBEEF; mem_busy = 4'b0010;
        smp(); check("bsy_wr", 32'({ack0, mem_wr, mem_rd}), 3'b110);
        check("bsy_wr_addr", 32'(mem_addr), 16'h0004);
        check("bsy_wdata", 32'(mem_wdata), 16'hBEEF);
        next(); wr0 = 0; mem_busy = 4'b0000; mem_stall = 1; rd0 = 1; addr0 = 16'h0006;
        req1 = 1; rd1 = 1; addr1 = 16'h0008;
        smp(); check("stall", 32'({ack0, ack1, mem_rd}), 0);
        check("stall_addr", 32'(mem_addr), 0);
        next(); mem_stall = 0; push_rd(1'b0, 16'h0006);
        smp(); check("nonown", 32'({ack0, ack1, mem_rd}), 3'b101);
        check("nonown_addr", 32'(mem_addr), 16'h0006);

        // Reads straddling a grant handoff
        next(); rd1 = 0; req1 = 0; addr0 = 16'h0020; push_rd(1'b0, 16'h0020);
        smp(); check("x_ack0", 32'(ack0), 1);
        next(); rd0 = 0; req0 = 0; req1 = 1; rd1 = 1; addr1 = 16'h0030;
        smp(); check("x_nonown", 32'({ack1, mem_rd}), 0);
        next(); push_rd(1'b1, 16'h0030);
        smp(); check("x_ack1", 32'({gnt1, ack1, mem_rd}), 3'b111);
        check("x_addr", 32'(mem_addr), 16'h0030);
        next(); rd1 = 0; req1 = 0; req0 = 1;
        smp();
        next();
        smp(); check("e_own0", 32'({gnt0, gnt1}), 2'b10);

        // Illegal rd&wr, then two reads in flight killed by reset
        next(); rd0 = 1; wr0 = 1; addr0 = 16'h000A;
        smp(); check("e_err", 32'({err, mem_rd, mem_wr, ack0}), 4'b1000);
        next(); wr0 = 0; push_rd(1'b0, 16'h000A);
        smp(); check("e_clear", 32'({err, ack0, mem_rd}), 3'b011);
        next(); addr0 = 16'h000C; push_rd(1'b0, 16'h000C);
        smp(); check("e_rd2", 32'(ack0), 1);
        next(); rst = 1; sb.delete(); clear_inputs();
        smp(); check("rst_mid", 32'(all_outs()), 0);
        next();
        next(); rst = 0;
        for (int i = 0; i < 5; i++) begin
            next();
            smp(); check("post_rst", 32'(all_outs()), 0);
        end
        check("sb_empty", 32'(sb.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
